// File: rtl/clock_work_if.sv
// Load/observe bundle for the clock_work time-of-day and calendar counter.
// The master drives load values and strobes; the slave returns the current time and date.
interface clock_work_if;
    logic [16:0] time_in;
    logic        time_ow;
    logic [16:0] time_out;
    logic [20:0] date_in;
    logic        date_ow;
    logic [20:0] date_out;

    modport master (
        output time_in,
        output time_ow,
        output date_in,
        output date_ow,
        input  time_out,
        input  date_out
    );

    modport slave (
        input  time_in,
        input  time_ow,
        input  date_in,
        input  date_ow,
        output time_out,
        output date_out
    );
endinterface

// File: rtl/clock_work.sv
// Seconds-driven time-of-day counter with a Gregorian calendar (12-bit year).
// One clk edge is one second; overwrite strobes take priority over advancing.
module clock_work (
    input  logic        clk,
    input  logic        rst,
    clock_work_if.slave bus
);

    localparam logic [16:0] TIME_RESET = 17'h0_0000;
    localparam logic [20:0] DATE_RESET = {5'd1, 4'd1, 12'd2020};

    // Year 0 is divisible by 400, so it falls out as a leap year naturally.
    function automatic logic is_leap(input logic [11:0] year);
        logic div4;
        logic div100;
        logic div400;
        div4   = (year[1:0] == 2'b00);
        div100 = ((year % 12'd100) == 12'd0);
        div400 = ((year % 12'd400) == 12'd0);
        return (div4 && !div100) || div400;
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic       leap);
        logic [4:0] days;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
            4'd2:                    days = leap ? 5'd29 : 5'd28;
            default:                 days = 5'd31;
        endcase
        return days;
    endfunction

    logic [5:0]  sec_r;
    logic [5:0]  min_r;
    logic [4:0]  hour_r;
    logic [4:0]  day_r;
    logic [3:0]  month_r;
    logic [11:0] year_r;

    logic        sec_wrap_s;
    logic        min_wrap_s;
    logic        hour_wrap_s;
    logic        day_roll_s;
    logic [5:0]  sec_adv_s;
    logic [5:0]  min_adv_s;
    logic [4:0]  hour_adv_s;

    logic [4:0]  dim_s;
    logic        day_wrap_s;
    logic        month_wrap_s;
    logic [4:0]  day_adv_s;
    logic [3:0]  month_adv_s;
    logic [11:0] year_adv_s;

    logic [16:0] time_nxt_s;
    logic [20:0] date_nxt_s;

    // One-second advance of the time fields; >= comparisons make out-of-range loads wrap.
    always_comb begin
        sec_wrap_s  = (sec_r  >= 6'd59);
        min_wrap_s  = (min_r  >= 6'd59);
        hour_wrap_s = (hour_r >= 5'd23);

        if (sec_wrap_s) begin
            sec_adv_s = 6'd0;
        end else begin
            sec_adv_s = sec_r + 6'd1;
        end

        if (sec_wrap_s) begin
            if (min_wrap_s) begin
                min_adv_s = 6'd0;
            end else begin
                min_adv_s = min_r + 6'd1;
            end
        end else begin
            min_adv_s = min_r;
        end

        if (sec_wrap_s && min_wrap_s) begin
            if (hour_wrap_s) begin
                hour_adv_s = 5'd0;
            end else begin
                hour_adv_s = hour_r + 5'd1;
            end
        end else begin
            hour_adv_s = hour_r;
        end

        day_roll_s = sec_wrap_s && min_wrap_s && hour_wrap_s;
    end

    // One-day advance of the calendar fields, used only on a midnight rollover.
    always_comb begin
        dim_s        = days_in_month(month_r, is_leap(year_r));
        day_wrap_s   = (day_r   >= dim_s);
        month_wrap_s = (month_r >= 4'd12);

        if (day_wrap_s) begin
            day_adv_s = 5'd1;
        end else begin
            day_adv_s = day_r + 5'd1;
        end

        if (day_wrap_s) begin
            if (month_wrap_s) begin
                month_adv_s = 4'd1;
                year_adv_s  = year_r + 12'd1;
            end else begin
                month_adv_s = month_r + 4'd1;
                year_adv_s  = year_r;
            end
        end else begin
            month_adv_s = month_r;
            year_adv_s  = year_r;
        end
    end

    // Overwrite-over-advance selection; a time load suppresses any rollover.
    always_comb begin
        if (bus.time_ow) begin
            time_nxt_s = bus.time_in;
        end else begin
            time_nxt_s = {hour_adv_s, min_adv_s, sec_adv_s};
        end

        if (bus.date_ow) begin
            date_nxt_s = bus.date_in;
        end else if (!bus.time_ow && day_roll_s) begin
            date_nxt_s = {day_adv_s, month_adv_s, year_adv_s};
        end else begin
            date_nxt_s = {day_r, month_r, year_r};
        end
    end

    // State registers with synchronous reset taking precedence over any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            {hour_r, min_r, sec_r}    <= TIME_RESET;
            {day_r, month_r, year_r}  <= DATE_RESET;
        end else begin
            {hour_r, min_r, sec_r}    <= time_nxt_s;
            {day_r, month_r, year_r}  <= date_nxt_s;
        end
    end

    assign bus.time_out = {hour_r, min_r, sec_r};
    assign bus.date_out = {day_r, month_r, year_r};

endmodule

// File: tb/tb_clock_work.sv
// Self-checking bench for clock_work: directed vector table, corner sequences,
// and randomized loads checked against an odometer-style calendar model.
module tb_clock_work;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clock_work_if bus ();

    clock_work dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r;
        logic        tow;
        logic        dow;
        logic [16:0] tin;
        logic [20:0] din;
        logic [16:0] et;
        logic [20:0] ed;
    } vec_t;

    vec_t tbl[$];

    // Model state: time fields {sec, min, hour} and date fields
    int mt[3];
    int m_d, m_mo, m_y;

    function automatic logic [16:0] mk_t(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [20:0] mk_d(input int d, input int mo, input int y);
        return {5'(d), 4'(mo), 12'(y)};
    endfunction

    function automatic int month_len(input int mo, input int y);
        int lens[13] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        bit leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        if (mo == 2) return leap ? 29 : 28;
        if (mo >= 1 && mo <= 12) return lens[mo];
        return 31;
    endfunction

    task automatic add(input logic r, input logic tow, input logic dow,
                       input logic [16:0] tin, input logic [20:0] din,
                       input logic [16:0] et, input logic [20:0] ed);
        vec_t v;
        v.r = r; v.tow = tow; v.dow = dow; v.tin = tin; v.din = din;
        v.et = et; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Apply inputs, then sample one time unit after the rising edge.
    task automatic step(input logic r, input logic tow, input logic dow,
                        input logic [16:0] tin, input logic [20:0] din);
        rst = r;
        bus.time_ow = tow;
        bus.date_ow = dow;
        bus.time_in = tin;
        bus.date_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic r, input logic tow, input logic dow,
                              input logic [16:0] tin, input logic [20:0] din);
        int lim[3] = '{59, 59, 23};
        bit carry;
        if (r) begin
            mt[0] = 0; mt[1] = 0; mt[2] = 0;
            m_d = 1; m_mo = 1; m_y = 2020;
        end else begin
            carry = 1'b0;
            if (tow) begin
                mt[0] = int'(tin[5:0]);
                mt[1] = int'(tin[11:6]);
                mt[2] = int'(tin[16:12]);
            end else begin
                carry = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (carry) begin
                        if (mt[i] >= lim[i]) begin
                            mt[i] = 0;
                        end else begin
                            mt[i] = mt[i] + 1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            if (dow) begin
                m_d  = int'(din[20:16]);
                m_mo = int'(din[15:12]);
                m_y  = int'(din[11:0]);
            end else if (carry) begin
                if (m_d >= month_len(m_mo, m_y)) begin
                    m_d = 1;
                    if (m_mo >= 12) begin
                        m_mo = 1;
                        m_y  = (m_y + 1) % 4096;
                    end else begin
                        m_mo = m_mo + 1;
                    end
                end else begin
                    m_d = m_d + 1;
                end
            end
        end
    endtask

    initial begin
        logic [16:0] t_last;
        logic [16:0] rt;
        logic [20:0] rd;
        logic        rr, rtow, rdow;
        logic [20:0] zero_d;
        t_last = mk_t(23, 59, 59);
        zero_d = 21'd0;

        rst = 1'b1;
        bus.time_ow = 1'b0;
        bus.date_ow = 1'b0;
        bus.time_in = 17'd0;
        bus.date_in = 21'd0;

        add(1, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(1, 1, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 1), mk_d(1, 1, 2020));
        add(0, 1, 1, t_last, mk_d(28, 2, 2020), t_last, mk_d(28, 2, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(29, 2, 2020));
        add(0, 1, 1, t_last, mk_d(28, 2, 2021), t_last, mk_d(28, 2, 2021));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(1, 3, 2021));
        add(0, 1, 1, t_last, mk_d(28, 2, 2100), t_last, mk_d(28, 2, 2100));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(1, 3, 2100));
        add(0, 1, 1, t_last, mk_d(28, 2, 2000), t_last, mk_d(28, 2, 2000));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(29, 2, 2000));
        add(0, 1, 1, t_last, mk_d(31, 12, 2020), t_last, mk_d(31, 12, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(1, 1, 2021));
        add(0, 1, 1, t_last, mk_d(31, 12, 4095), t_last, mk_d(31, 12, 4095));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(1, 1, 0));
        add(0, 1, 1, t_last, mk_d(30, 4, 2020), t_last, mk_d(30, 4, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(1, 5, 2020));
        add(0, 1, 1, t_last, mk_d(30, 5, 2020), t_last, mk_d(30, 5, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(31, 5, 2020));
        add(0, 1, 1, t_last, mk_d(10, 6, 2020), t_last, mk_d(10, 6, 2020));
        add(0, 0, 1, 17'd0, mk_d(5, 7, 2022), mk_t(0, 0, 0), mk_d(5, 7, 2022));
        add(0, 1, 0, t_last, zero_d, t_last, mk_d(5, 7, 2022));
        add(0, 1, 0, mk_t(0, 0, 0), zero_d, mk_t(0, 0, 0), mk_d(5, 7, 2022));
        add(1, 1, 1, t_last, mk_d(9, 9, 1999), mk_t(0, 0, 0), mk_d(1, 1, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 1), mk_d(1, 1, 2020));
        add(0, 1, 0, mk_t(23, 63, 59), zero_d, mk_t(23, 63, 59), mk_d(1, 1, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(2, 1, 2020));
        add(0, 1, 1, t_last, mk_d(30, 0, 2020), t_last, mk_d(30, 0, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(31, 0, 2020));
        add(0, 1, 1, t_last, mk_d(28, 2, 0), t_last, mk_d(28, 2, 0));
        add(0, 0, 0, 17'd0, zero_d, mk_t(0, 0, 0), mk_d(29, 2, 0));
        add(0, 1, 1, mk_t(31, 10, 10), mk_d(3, 3, 2020), mk_t(31, 10, 10), mk_d(3, 3, 2020));
        add(0, 0, 0, 17'd0, zero_d, mk_t(31, 10, 11), mk_d(3, 3, 2020));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].tow, tbl[i].dow, tbl[i].tin, tbl[i].din);
            check($sformatf("vec%0d_time", i), {4'd0, bus.time_out}, {4'd0, tbl[i].et});
            check($sformatf("vec%0d_date", i), bus.date_out, tbl[i].ed);
        end

        // Twelve minutes to midnight from a simultaneous load
        step(0, 1, 1, 17'b10111_110000_000000, 21'b01111_0001_011111100100);
        for (int i = 0; i < 719; i++) step(0, 0, 0, 17'd0, zero_d);
        check("run719_time", {4'd0, bus.time_out}, {4'd0, t_last});
        check("run719_date", bus.date_out, mk_d(15, 1, 2020));
        step(0, 0, 0, 17'd0, zero_d);
        check("run720_time", {4'd0, bus.time_out}, 21'd0);
        check("run720_date", bus.date_out, mk_d(16, 1, 2020));

        // Reset in the middle of counting discards all progress
        for (int i = 0; i < 37; i++) step(0, 0, 0, 17'd0, zero_d);
        step(1, 0, 0, 17'd0, zero_d);
        check("midrst_time", {4'd0, bus.time_out}, 21'd0);
        check("midrst_date", bus.date_out, mk_d(1, 1, 2020));
        step(0, 0, 0, 17'd0, zero_d);
        check("midrst_next", {4'd0, bus.time_out}, {4'd0, mk_t(0, 0, 1)});

        // Randomized loads and resets against the model
        step(1, 0, 0, 17'd0, zero_d);
        model_step(1, 0, 0, 17'd0, zero_d);
        for (int i = 0; i < 600; i++) begin
            rr   = ($urandom_range(0, 63) == 0);
            rtow = ($urandom_range(0, 7) == 0);
            rdow = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) rt = 17'($urandom);
            else rt = mk_t(23, 59, $urandom_range(50, 63));
            case ($urandom_range(0, 3))
                0: rd = mk_d($urandom_range(1, 31), $urandom_range(0, 15), $urandom_range(0, 4095));
                1: rd = mk_d($urandom_range(27, 31), 2, 2000 + 100 * $urandom_range(0, 1));
                2: rd = mk_d($urandom_range(28, 31), 12, 4095);
                default: rd = mk_d($urandom_range(28, 31), $urandom_range(1, 12), 2020 + $urandom_range(0, 4));
            endcase
            step(rr, rtow, rdow, rt, rd);
            model_step(rr, rtow, rdow, rt, rd);
            check($sformatf("rnd%0d_time", i), {4'd0, bus.time_out},
                  {4'd0, mk_t(mt[2], mt[1], mt[0])});
            check($sformatf("rnd%0d_date", i), bus.date_out, mk_d(m_d, m_mo, m_y));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_work.md
CLOCK_WORK -- requirements
Module: clock_work

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  system clock; one rising edge = one second of clock time.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 time_in  input  17  time load value {hour[16:12], min[11:6], sec[5:0]}, binary.
REQ-005 time_ow  input  1  time overwrite strobe; active-high.
REQ-006 time_out  output  17  current time, same packing as time_in.
REQ-007 date_in  input  21  date load value {day[20:16], month[15:12], year[11:0]}, binary, day/month 1-based.
REQ-008 date_ow  input  1  date overwrite strobe; active-high.
REQ-009 date_out  output  21  current date, same packing as date_in.

Function
REQ-010 All state SHALL update only on the rising edge of clk; outputs SHALL be driven directly from registers.
REQ-011 Priority per edge SHALL be: rst, then overwrite, then advance.
REQ-012 time_ow=1: time_out SHALL load time_in verbatim on that edge; time SHALL NOT advance on that edge.
REQ-013 time_ow=0: time SHALL advance by one second per edge.
REQ-014 Second counting: sec<59 -> sec+1; sec>=59 -> sec=0 with carry into minutes.
REQ-015 Minute carry: min<59 -> min+1; min>=59 -> min=0 with carry into hours.
REQ-016 Hour carry: hour<23 -> hour+1; hour>=23 -> hour=0 and a day-rollover pulse is raised for that edge.
REQ-017 Out-of-range loaded fields (sec/min>59, hour>23) SHALL be treated as the field maximum on the next advance, i.e. wrap to 0 with carry.
REQ-018 date_ow=1: date_out SHALL load date_in verbatim on that edge, and a day-rollover on the same edge SHALL be ignored.
REQ-019 date_ow=0: date SHALL advance by one day exactly on edges where the time advances from hour 23/min 59/sec 59 to 00:00:00; otherwise it SHALL hold.
REQ-020 A time_ow load SHALL never advance the date, whatever the loaded value.
REQ-021 Days in month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for month 2 in leap years, else 28; 31 for illegal months 0 and 13-15.
REQ-022 Leap year: year divisible by 4 and not by 100, or divisible by 400; year 0 counts as leap.
REQ-023 Day advance: day<days_in_month -> day+1; day>=days_in_month -> day=1 with month carry.
REQ-024 Month carry: month<12 -> month+1; month>=12 -> month=1 and year+1.
REQ-025 Year SHALL wrap 4095 -> 0.
REQ-026 time_ow and date_ow asserted together SHALL load both values; neither advances on that edge.

Reset
REQ-027 rst=1 SHALL set time_out to 00:00:00 (17'h0) and date_out to 01.01.2020 ({5'd1, 4'd1, 12'd2020}) on the edge it is sampled, overriding time_ow and date_ow.
REQ-028 Counting SHALL resume on the first edge with rst=0: the first advanced value after reset is 00:00:01.
REQ-029 Reset asserted mid-count SHALL discard all progress; no partial carry SHALL survive.

Verification
REQ-030 Load 23:48:00 (17'b10111_110000_000000) and 15.01.2020 (21'b01111_0001_011111100100) with both strobes high for one edge, then free-run 720 edges -> time_out 00:00:00, date_out 16.01.2020; after 719 edges -> 23:59:59, 15.01.2020.
REQ-031 Leap handling: 23:59:59 plus one edge -> 28.02.2020 becomes 29.02.2020; 28.02.2021 becomes 01.03.2021; 28.02.2100 becomes 01.03.2100; 28.02.2000 becomes 29.02.2000.
REQ-032 Year rollover: 31.12.2020 23:59:59 plus one edge -> 01.01.2021 00:00:00; 31.12.4095 plus one edge -> 01.01.0000.
REQ-033 Month lengths: 30.04.2020 at 23:59:59 -> 01.05.2020; 30.05.2020 -> 31.05.2020.
REQ-034 Priority: date_ow=1 on the edge time rolls 23:59:59 -> 00:00:00 -> date_out equals date_in; time_ow=1 loading 00:00:00 from 23:59:59 -> date unchanged.
REQ-035 Reset: rst=1 for one edge during counting, also with both strobes high -> 00:00:00 / 01.01.2020; next edge with rst=0 -> 00:00:01.
